// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the iterative multiply/divide unit.
//   op_e    : operation codes carried on the op port
//   state_e : control FSM states (IDLE, RUN, FIX)
//   ITERS   : number of radix-2 steps per operation
package muldiv_pkg;

  localparam int ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// muldiv_addsub -- combinational adder/subtractor shared by the multiply
// (shift-add) and divide (restoring subtract) steps.
//   a, b : operands (W bits)
//   sub  : 1 selects a - b, 0 selects a + b
//   y    : result (W bits, no carry-out beyond W)
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative 32-cycle MULT/MULTU/DIV/DIVU unit with the
// architectural HI/LO registers.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, op       : launch an operation (op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU)
//   srca, srcb      : operands
//   hi_we, lo_we, wd: MTHI/MTLO writes (honoured only in IDLE, start wins)
//   busy            : operation in progress (state != IDLE)
//   done            : one-cycle pulse after HI/LO take a result
//   hi, lo          : HI/LO registers
// Handshake: start is sampled only when busy=0; there is no backpressure, the
// result lands in hi/lo exactly 33 edges after the accepting edge and done
// marks the cycle in which it becomes visible.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [M-1:0] srca,
  input  logic [M-1:0] srcb,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [M-1:0] wd,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] hi,
  output logic [M-1:0] lo
);

  state_e           state, state_next;
  logic [5:0]       count;
  logic [2*M-1:0]   acc;       // multiply: {partial, multiplier}; divide: {rem, quot}
  logic [M-1:0]     mag_b;     // multiplicand / divisor magnitude
  op_e              op_q;
  logic             neg_q;     // product or quotient must be negated
  logic             neg_r;     // remainder must be negated (dividend sign)
  logic             div0;

  op_e              op_in;
  logic             sa, sb;
  logic [M-1:0]     a_mag, b_mag;
  logic             is_div_q;
  logic [M:0]       as_a, as_b, as_y;
  logic [2*M-1:0]   acc_step;
  logic [2*M-1:0]   prod;
  logic [M-1:0]     hi_res, lo_res;

  // ---------------- operand conditioning ----------------
  assign op_in = op_e'(op);
  assign sa    = op_is_signed(op_in) && srca[M-1];
  assign sb    = op_is_signed(op_in) && srcb[M-1];
  assign a_mag = sa ? -srca : srca;
  assign b_mag = sb ? -srcb : srcb;

  // ---------------- one radix-2 step ----------------
  assign is_div_q = op_is_div(op_q);
  // Divide compares the remainder shifted left by one (top M+1 bits of acc
  // before the shift); multiply adds the multiplicand into the upper half.
  assign as_a = is_div_q ? acc[2*M-1:M-1] : {1'b0, acc[2*M-1:M]};
  assign as_b = {1'b0, mag_b};

  muldiv_addsub #(.W(M + 1)) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (is_div_q),
    .y   (as_y)
  );

  always_comb begin
    acc_step = acc;
    if (is_div_q) begin
      // No borrow means the divisor fits: keep the difference, quotient bit 1.
      if (!as_y[M]) acc_step = {as_y[M-1:0], acc[M-2:0], 1'b1};
      else          acc_step = {acc[2*M-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_step = {as_y, acc[M-1:1]};
      else        acc_step = {1'b0, acc[2*M-1:1]};
    end
  end

  // ---------------- sign correction for FIX ----------------
  // With a zero divisor the remainder half ends up holding |srca|, so the
  // normal remainder sign fix reproduces srca; only lo needs forcing.
  always_comb begin
    prod   = neg_q ? -acc : acc;
    hi_res = prod[2*M-1:M];
    lo_res = prod[M-1:0];
    if (is_div_q) begin
      hi_res = neg_r ? -acc[2*M-1:M] : acc[2*M-1:M];
      if (div0)       lo_res = '1;
      else if (neg_q) lo_res = -acc[M-1:0];
      else            lo_res = acc[M-1:0];
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == 6'(ITERS - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // ---------------- datapath and HI/LO ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      acc   <= '0;
      mag_b <= '0;
      op_q  <= OP_MULT;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            count <= '0;
            acc   <= {{M{1'b0}}, a_mag};
            mag_b <= b_mag;
            op_q  <= op_in;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            div0  <= op_is_div(op_in) && (srcb == '0);
          end else begin
            if (hi_we) hi <= wd;
            if (lo_we) lo <= wd;
          end
        end
        RUN: begin
          acc   <= acc_step;
          count <= count + 6'd1;
        end
        FIX: begin
          hi <= hi_res;
          lo <= lo_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed and random checks of muldiv_unit against an
// arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca, srcb, wd;
  logic        hi_we, lo_we;
  logic        busy, done;
  logic [31:0] hi, lo;

  int passed = 0;
  int total  = 0;

  muldiv_unit #(.M(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: returns {hi, lo} ----------------
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return ua * ub;
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == OP_DIV) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- driver: one full operation ----------------
  // Optionally asserts hi_we/lo_we together with start (must be dropped) and
  // always pokes hi_we/lo_we mid-run (must be ignored).
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit we_with_start);
    logic [63:0] exp;
    logic [31:0] hi0, lo0;
    int          k;
    bit          stable;
    exp = model(o, a, b);
    @(negedge clk);
    op = o; srca = a; srcb = b; start = 1'b1;
    hi0 = hi; lo0 = lo;
    if (we_with_start) begin hi_we = 1'b1; lo_we = 1'b1; wd = $urandom; end
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    srca = $urandom; srcb = $urandom; op = 2'($urandom_range(0, 3));
    check({tag, " busy"}, {63'b0, busy}, 64'd1);
    k = 0; stable = 1'b1;
    if (hi !== hi0 || lo !== lo0) stable = 1'b0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
      if (k == 5) begin hi_we = 1'b1; lo_we = 1'b1; wd = $urandom; end
      if (k == 6) begin hi_we = 1'b0; lo_we = 1'b0; end
      if (!done && (hi !== hi0 || lo !== lo0)) stable = 1'b0;
    end
    hi_we = 1'b0; lo_we = 1'b0;
    check({tag, " latency"}, 64'(k), 64'd33);
    check({tag, " hilo_held"}, {63'b0, stable}, 64'd1);
    check({tag, " result"}, {hi, lo}, exp);
    check({tag, " busy_at_done"}, {63'b0, busy}, 64'd0);
    @(negedge clk);
    check({tag, " done_one_cycle"}, {62'b0, done, busy}, 64'd0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    int          k;
    logic [31:0] ra, rb, hi0, lo0;
    logic [1:0]  ro;

    rst_n = 1'b0; start = 1'b0; op = 2'd0; srca = '0; srcb = '0;
    wd = '0; hi_we = 1'b0; lo_we = 1'b0;
    #1;
    check("reset_state", {30'b0, busy, done, hi}, 64'd0);
    check("reset_lo", {32'b0, lo}, 64'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // directed operations with known constant results
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_neg3x7_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg7by2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 1'b0);
    check("divu_by0_const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    run_op("div_by0_neg", OP_DIV, 32'h8000_0005, 32'd0, 1'b0);
    run_op("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_overflow_const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);

    // MTHI / MTLO in IDLE
    @(negedge clk); hi_we = 1'b1; wd = 32'hCAFE_0001;
    @(negedge clk); hi_we = 1'b0; lo0 = lo;
    check("mthi", {hi, lo}, {32'hCAFE_0001, lo0});
    lo_we = 1'b1; wd = 32'hBEEF_0002;
    @(negedge clk); lo_we = 1'b0;
    check("mtlo", {hi, lo}, 64'hCAFE_0001_BEEF_0002);
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'h0A0B_0C0D;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_mtlo", {hi, lo}, 64'h0A0B_0C0D_0A0B_0C0D);

    // start together with MTHI/MTLO: start wins
    run_op("start_beats_we", OP_DIVU, 32'd50, 32'd7, 1'b1);

    // second start and hi_we during a run are ignored
    @(negedge clk);
    op = OP_MULTU; srca = 32'd5; srcb = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
      if (k == 9)  begin start = 1'b1; op = OP_DIVU; srca = 32'd9; srcb = 32'd3; end
      if (k == 10) start = 1'b0;
      if (k == 11) begin hi_we = 1'b1; wd = 32'h1234; end
      if (k == 12) hi_we = 1'b0;
    end
    start = 1'b0; hi_we = 1'b0;
    check("ignore_latency", 64'(k), 64'd33);
    check("ignore_result", {hi, lo}, 64'h0000_0000_0000_001E);
    k = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) k++;
    end
    check("ignore_no_second_op", 64'(k), 64'd0);
    check("ignore_hilo_kept", {hi, lo}, 64'h0000_0000_0000_001E);

    // reset in the middle of a MULT
    @(negedge clk);
    op = OP_MULT; srca = 32'hFFFF_FFFB; srcb = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrun_reset", {30'b0, busy, done, hi}, 64'd0);
    check("midrun_reset_lo", {32'b0, lo}, 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_op("after_reset", OP_MULT, 32'd7, 32'hFFFF_FFF8, 1'b0);
    @(negedge clk); hi_we = 1'b1; wd = 32'h1234;
    lo0 = lo;
    @(negedge clk); hi_we = 1'b0;
    check("mthi_after_reset", {hi, lo}, {32'h0000_1234, lo0});

    // random operations
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, ($urandom_range(0, 4) == 0));
    end

    hi0 = hi;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
